// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Brief    : Runs the vend motor and pays change through a 10 tk and a 5 tk
//            hopper for each request from the vending FSM. Define
//            PAYOUT_AUDIT_EN to add a saturating total_paid_tk output.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int VEND_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        purchase,
  input  logic [1:0]  cash_return,
  input  logic        coin_seen,
  input  logic        clear_fault,
  output logic        ready,
  output logic        vend_motor,
  output logic        eject_10,
  output logic        eject_5,
  output logic        done,
  output logic        fault
`ifdef PAYOUT_AUDIT_EN
  ,
  output logic [15:0] total_paid_tk
`endif
);

  localparam int c_CNT_MAX = (VEND_CYCLES > GAP_CYCLES) ? VEND_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_TMR_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_VEND_LAST = c_CNT_W'(VEND_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VEND    = 3'd1,
    ST_EJECT10 = 3'd2,
    ST_EJECT5  = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_need10;
  logic               r_need5;
  logic [5:0]         r_outs;

  // Output word order: {ready, vend_motor, eject_10, eject_5, done, fault}
  function automatic logic [5:0] f_outputs(input state_t s);
    case (s)
      ST_IDLE:    return 6'b100000;
      ST_VEND:    return 6'b010000;
      ST_EJECT10: return 6'b001000;
      ST_EJECT5:  return 6'b000100;
      ST_DONE:    return 6'b000010;
      ST_FAULT:   return 6'b000001;
      default:    return 6'b000000;
    endcase
  endfunction

  assign {ready, vend_motor, eject_10, eject_5, done, fault} = r_outs;

  // Outputs are loaded alongside the next state, so they are a registered
  // decode of the state they belong to. Counters are cleared on every exit
  // so each stage starts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_outs   <= f_outputs(ST_IDLE);
      r_cnt    <= '0;
      r_timer  <= '0;
      r_need10 <= 1'b0;
      r_need5  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_need10 <= cash_return[1];
            r_need5  <= cash_return[0];
            r_cnt    <= '0;
            r_timer  <= '0;
            if (purchase) begin
              r_state <= ST_VEND;
              r_outs  <= f_outputs(ST_VEND);
            end else if (cash_return[1]) begin
              r_state <= ST_EJECT10;
              r_outs  <= f_outputs(ST_EJECT10);
            end else if (cash_return[0]) begin
              r_state <= ST_EJECT5;
              r_outs  <= f_outputs(ST_EJECT5);
            end else begin
              r_state <= ST_DONE;
              r_outs  <= f_outputs(ST_DONE);
            end
          end
        end

        ST_VEND: begin
          if (r_cnt == c_VEND_LAST) begin
            r_cnt <= '0;
            if (r_need10) begin
              r_state <= ST_EJECT10;
              r_outs  <= f_outputs(ST_EJECT10);
            end else if (r_need5) begin
              r_state <= ST_EJECT5;
              r_outs  <= f_outputs(ST_EJECT5);
            end else begin
              r_state <= ST_DONE;
              r_outs  <= f_outputs(ST_DONE);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_EJECT10: begin
          // A coin on the final timeout cycle still counts as paid.
          if (coin_seen) begin
            r_timer  <= '0;
            r_need10 <= 1'b0;
            if (r_need5) begin
              r_state <= ST_GAP;
              r_outs  <= f_outputs(ST_GAP);
            end else begin
              r_state <= ST_DONE;
              r_outs  <= f_outputs(ST_DONE);
            end
          end else if (r_timer == c_TMR_LAST) begin
            r_timer <= '0;
            r_state <= ST_FAULT;
            r_outs  <= f_outputs(ST_FAULT);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_EJECT5: begin
          if (coin_seen) begin
            r_timer <= '0;
            r_need5 <= 1'b0;
            r_state <= ST_DONE;
            r_outs  <= f_outputs(ST_DONE);
          end else if (r_timer == c_TMR_LAST) begin
            r_timer <= '0;
            r_state <= ST_FAULT;
            r_outs  <= f_outputs(ST_FAULT);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_EJECT5;
            r_outs  <= f_outputs(ST_EJECT5);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_outs  <= f_outputs(ST_IDLE);
        end

        ST_FAULT: begin
          // Unpaid remainder is dropped when the fault is cleared.
          if (clear_fault) begin
            r_need10 <= 1'b0;
            r_need5  <= 1'b0;
            r_state  <= ST_IDLE;
            r_outs   <= f_outputs(ST_IDLE);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_outs  <= f_outputs(ST_IDLE);
        end
      endcase
    end
  end

`ifdef PAYOUT_AUDIT_EN
  logic [15:0] r_total;
  logic [4:0]  w_add;
  logic [16:0] w_sum;

  always_comb begin
    w_add = 5'd0;
    if (coin_seen && (r_state == ST_EJECT10)) begin
      w_add = 5'd10;
    end else if (coin_seen && (r_state == ST_EJECT5)) begin
      w_add = 5'd5;
    end
  end

  assign w_sum = {1'b0, r_total} + {12'd0, w_add};

  // Saturating running total of coins actually paid out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_total <= 16'd0;
    end else if (w_add != 5'd0) begin
      r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign total_paid_tk = r_total;
`endif

endmodule
`default_nettype wire
